// File: rtl/codec_pkg.sv
// Shared audio types: sample width, stereo pair layout and I2S slot helpers.
package codec_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_W     = 5;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t lft;
        sample_t rht;
    } stereo_t;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_RST  = 5'd30;
    localparam slot_t SLOT_LAST = 5'd31;

    // Word select leads the data by one slot: right slot spans 15..30.
    function automatic logic ws_of(slot_t s);
        return (s >= 5'd15) && (s <= 5'd30);
    endfunction

endpackage

// File: rtl/codec_clkgen.sv
// Bit clock, word select and slot index generator for the I2S transmitter.
module codec_clkgen
    import codec_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    output logic  sclk,
    output logic  lrclk,
    output slot_t slot,
    output logic  fall_stb
);

    localparam logic [7:0] DIV_MAX = 8'(BCLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       wrap;
    slot_t      slot_nxt;

    assign wrap     = (div_cnt == DIV_MAX);
    assign fall_stb = wrap & sclk;
    assign slot_nxt = slot + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            slot    <= SLOT_RST;
            lrclk   <= 1'b1;
        end else begin
            div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
            if (wrap) begin
                sclk <= ~sclk;
            end
            if (fall_stb) begin
                slot  <= slot_nxt;
                lrclk <= ws_of(slot_nxt);
            end
        end
    end

endmodule

// File: rtl/codec_tx.sv
// I2S DAC transmitter: valid/ready holding register feeding a 32-bit shifter.
// Optional CODEC_TX_MUTE_EN adds a mute input that zeroes loaded frames.
module codec_tx
    import codec_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef CODEC_TX_MUTE_EN
    input  logic                       mute,
`endif
    input  logic signed [SAMPLE_W-1:0] lft,
    input  logic signed [SAMPLE_W-1:0] rht,
    input  logic                       vld,
    output logic                       rdy,
    output logic                       sclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic                       frm_strt,
    output logic                       underflow
);

    slot_t                 slot;
    logic                  fall_stb;
    logic                  load;
    logic                  accept;
    logic                  mute_w;
    logic                  full_q;
    logic                  full_nxt;
    stereo_t               hold_q;
    stereo_t               frame_nxt;
    logic [FRAME_BITS-1:0] shreg;

    codec_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .slot     (slot),
        .fall_stb (fall_stb)
    );

`ifdef CODEC_TX_MUTE_EN
    assign mute_w = mute;
`else
    assign mute_w = 1'b0;
`endif

    assign load   = fall_stb && (slot == SLOT_LAST);
    assign accept = vld && rdy;
    assign sdata  = shreg[FRAME_BITS-1];

    // A load frees the holding register before a same-edge accept refills it.
    always_comb begin
        full_nxt = full_q;
        if (load) begin
            full_nxt = 1'b0;
        end
        if (accept) begin
            full_nxt = 1'b1;
        end
    end

    always_comb begin
        frame_nxt = '0;
        if (full_q && !mute_w) begin
            frame_nxt = hold_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            rdy       <= 1'b1;
            hold_q    <= '0;
            shreg     <= '0;
            frm_strt  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            full_q    <= full_nxt;
            rdy       <= ~full_nxt;
            frm_strt  <= load;
            underflow <= load && !full_q;
            if (accept) begin
                hold_q.lft <= lft;
                hold_q.rht <= rht;
            end
            if (load) begin
                shreg <= frame_nxt;
            end else if (fall_stb) begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_codec_tx.sv
// Directed bench for codec_tx at BCLK_DIV=2 (4 clk per bit, 128 clk per frame).
module tb_codec_tx;

    typedef struct {
        logic [15:0] lft;
        logic [15:0] rht;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] LR_EXP = 32'h0001_FFFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lft = '0;
    logic [15:0] rht = '0;
    logic        vld = 1'b0;
    logic        rdy, sclk, lrclk, sdata, frm_strt, underflow;
`ifdef CODEC_TX_MUTE_EN
    logic        mute = 1'b0;
`endif

    int   n_run = 0;
    int   n_fail = 0;
    int   idx = 0;
    int   lim = 0;
    int   acc = 0;
    logic bump = 1'b0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    codec_tx #(
        .BCLK_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CODEC_TX_MUTE_EN
        .mute      (mute),
`endif
        .lft       (lft),
        .rht       (rht),
        .vld       (vld),
        .rdy       (rdy),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .frm_strt  (frm_strt),
        .underflow (underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " sclk"}, 32'(sclk), 32'd0);
        chk({tag, " lrclk"}, 32'(lrclk), 32'd1);
        chk({tag, " sdata"}, 32'(sdata), 32'd0);
        chk({tag, " rdy"}, 32'(rdy), 32'd1);
        chk({tag, " frm_strt"}, 32'(frm_strt), 32'd0);
        chk({tag, " underflow"}, 32'(underflow), 32'd0);
    endtask

    task automatic present();
        if (idx < lim) begin
            vld = 1'b1;
            lft = vecs[idx].lft;
            rht = vecs[idx].rht;
        end else begin
            vld = 1'b0;
        end
    endtask

    task automatic accept_chk();
        if (rdy && vld) begin
            bump = 1'b1;
            acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bump) begin
            bump = 1'b0;
            idx++;
            present();
        end
        accept_chk();
    endtask

    task automatic wait_frm(output int n);
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (frm_strt) break;
        end
        if (!frm_strt) chk("frm_strt timeout", 32'(n), 32'd0);
    endtask

    // Called on the negedge where frm_strt is high (slot 0, bit 31).
    task automatic capture(output logic [31:0] w, output logic [31:0] lr,
                           output logic u0, output logic r0,
                           output logic r1, output int ufs,
                           output int rises);
        logic sp;
        w = '0; lr = '0; ufs = 0; rises = 0; r1 = 1'b0;
        u0 = underflow; r0 = rdy; sp = sclk;
        w[31] = sdata; lr[31] = lrclk;
        for (int c = 1; c < 128; c++) begin
            tick();
            if (c == 1) r1 = rdy;
            if (underflow) ufs++;
            if (sclk && !sp) rises++;
            sp = sclk;
            if (c % 4 == 0) begin
                w[31 - c / 4] = sdata;
                lr[31 - c / 4] = lrclk;
            end
        end
    endtask

    initial begin
        logic [31:0] w, lr;
        logic        u0, r0, r1;
        int          ufs, rises, n;

        vecs[0] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 32'hA5A5_5A5A};
        vecs[4] = '{16'h0001, 16'h8000, 32'h0001_8000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF};
        vecs[6] = '{16'h1234, 16'hABCD, 32'h0000_0000};

        @(negedge clk);
        chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;

        wait_frm(n);
        chk("first load latency", 32'(n), 32'd8);
        chk("idle underflow", 32'(underflow), 32'd1);
        capture(w, lr, u0, r0, r1, ufs, rises);
        chk("idle sdata", w, 32'd0);
        chk("idle lrclk", lr, LR_EXP);
        chk("sclk rises/frame", 32'(rises), 32'd32);
        wait_frm(n);
        chk("frame period tail", 32'(n), 32'd1);
        chk("idle underflow 2", 32'(underflow), 32'd1);

        // Pair offered on the frm_strt cycle of an empty frame.
        idx = 0; lim = 5; acc = 0;
        present();
        accept_chk();
        capture(w, lr, u0, r0, r1, ufs, rises);
        chk("late pair zero frame", w, 32'd0);
        chk("late pair underflow", 32'(u0), 32'd1);
        chk("late pair accepts", 32'(acc), 32'd1);

        for (int i = 0; i < 5; i++) begin
            acc = 0;
            wait_frm(n);
            capture(w, lr, u0, r0, r1, ufs, rises);
            chk($sformatf("v%0d word", i), w, vecs[i].exp);
            chk($sformatf("v%0d lrclk", i), lr, LR_EXP);
            chk($sformatf("v%0d underflow", i), 32'(u0) + 32'(ufs), 32'd0);
            chk($sformatf("v%0d rdy@frm", i), 32'(r0), 32'd1);
            chk($sformatf("v%0d rdy+1", i), 32'(r1), (i < 4) ? 32'd0 : 32'd1);
            chk($sformatf("v%0d accepts", i), 32'(acc), (i < 4) ? 32'd1 : 32'd0);
        end

        wait_frm(n);
        chk("drained underflow", 32'(underflow), 32'd1);
        idx = 5; lim = 6;
        present();
        accept_chk();
        wait_frm(n);
        repeat (80) tick();
        chk("pre-reset sdata", 32'(sdata), 32'd1);
        chk("pre-reset lrclk", 32'(lrclk), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_rst("mid reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frm(n);
        chk("post-reset latency", 32'(n), 32'd8);
        chk("post-reset underflow", 32'(underflow), 32'd1);

`ifdef CODEC_TX_MUTE_EN
        mute = 1'b1;
        idx = 6; lim = 7;
        present();
        accept_chk();
        wait_frm(n);
        capture(w, lr, u0, r0, r1, ufs, rises);
        chk("mute word", w, vecs[6].exp);
        chk("mute underflow", 32'(u0), 32'd0);
        chk("mute rdy@frm", 32'(r0), 32'd1);
        mute = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
